// File: rtl/threshold_monitor_4bit.sv
// Registered threshold compare with hysteresis-debounced alarm and peak tracking.
// All flags, alarm and peak update on the edge that consumes a valid sample.
module threshold_monitor_4bit #(
    parameter int                DATA_W    = 4,
    parameter int                DEBOUNCE  = 3,
    parameter logic [DATA_W-1:0] THR_RESET = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              thr_load,
    input  logic [DATA_W-1:0] thr_in,
    input  logic              clear_peak,
    output logic              above,
    output logic              below,
    output logic              equal,
    output logic              alarm,
    output logic [DATA_W-1:0] peak,
    output logic              peak_valid
);
    localparam int                CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  DEB_C  = CNT_W'(DEBOUNCE);
    localparam logic [0:0]        S_LOW  = 1'b0;
    localparam logic [0:0]        S_HIGH = 1'b1;

    logic [DATA_W-1:0] r_thr;
    logic [CNT_W-1:0]  r_cnt;
    logic [0:0]        r_state;
    logic              r_above_p1;
    logic              r_below_p1;
    logic              r_equal_p1;
    logic [DATA_W-1:0] r_peak_p1;
    logic              r_peak_vld_p1;

    logic              w_take;
    logic              w_gt;
    logic              w_lt;
    logic              w_eq;
    logic              w_qual;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_peak_upd;

    // A sample arriving together with a threshold load is dropped entirely.
    assign w_take     = sample_valid && !thr_load;
    assign w_gt       = sample > r_thr;
    assign w_lt       = sample < r_thr;
    assign w_eq       = sample == r_thr;
    assign w_qual     = (r_state == S_LOW) ? w_gt : w_lt;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_peak_upd = w_take && (clear_peak || !r_peak_vld_p1 || (sample > r_peak_p1));

    // Stage p1: compare flags, debounce FSM, peak register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_thr         <= THR_RESET;
            r_cnt         <= '0;
            r_state       <= S_LOW;
            r_above_p1    <= 1'b0;
            r_below_p1    <= 1'b0;
            r_equal_p1    <= 1'b0;
            r_peak_p1     <= '0;
            r_peak_vld_p1 <= 1'b0;
        end else begin
            if (thr_load) begin
                r_thr <= thr_in;
                r_cnt <= '0;
            end else if (sample_valid) begin
                r_above_p1 <= w_gt;
                r_below_p1 <= w_lt;
                r_equal_p1 <= w_eq;
                // Equal samples never qualify in either state: the hysteresis band.
                if (!w_qual) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc == DEB_C) begin
                    r_cnt   <= '0;
                    r_state <= (r_state == S_LOW) ? S_HIGH : S_LOW;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end

            if (w_peak_upd) begin
                r_peak_p1     <= sample;
                r_peak_vld_p1 <= 1'b1;
            end else if (clear_peak && !w_take) begin
                r_peak_p1     <= '0;
                r_peak_vld_p1 <= 1'b0;
            end
        end
    end

    assign above      = r_above_p1;
    assign below      = r_below_p1;
    assign equal      = r_equal_p1;
    assign alarm      = (r_state == S_HIGH);
    assign peak       = r_peak_p1;
    assign peak_valid = r_peak_vld_p1;
endmodule

// File: tb/tb_threshold_monitor_4bit.sv
// Bench for threshold_monitor_4bit: directed vector table, then random stimulus vs a reference model.
module tb_threshold_monitor_4bit;
    logic       clk = 1'b0;
    logic       rst_n, sample_valid, thr_load, clear_peak;
    logic [3:0] sample, thr_in;
    logic       above, below, equal, alarm, peak_valid;
    logic [3:0] peak;
    logic       above1, below1, equal1, alarm1, peak_valid1;
    logic [3:0] peak1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    threshold_monitor_4bit #(.DATA_W(4), .DEBOUNCE(3), .THR_RESET(4'b1000)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_load(thr_load), .thr_in(thr_in), .clear_peak(clear_peak),
        .above(above), .below(below), .equal(equal), .alarm(alarm),
        .peak(peak), .peak_valid(peak_valid)
    );

    threshold_monitor_4bit #(.DATA_W(4), .DEBOUNCE(1), .THR_RESET(4'b1000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_load(thr_load), .thr_in(thr_in), .clear_peak(clear_peak),
        .above(above1), .below(below1), .equal(equal1), .alarm(alarm1),
        .peak(peak1), .peak_valid(peak_valid1)
    );

    typedef struct {
        logic       rn, v, tl, cp;
        logic [3:0] s, ti;
        logic [8:0] exp;   // {above, below, equal, alarm, peak[3:0], peak_valid}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rn, int v, int s, int tl, int ti, int cp,
                                int a, int b, int e, int al, int pk, int pv);
        vec_t r;
        r.rn  = 1'(rn);
        r.v   = 1'(v);
        r.s   = 4'(s);
        r.tl  = 1'(tl);
        r.ti  = 4'(ti);
        r.cp  = 1'(cp);
        r.exp = {1'(a), 1'(b), 1'(e), 1'(al), 4'(pk), 1'(pv)};
        return r;
    endfunction

    task automatic drive(input logic rn, input logic v, input logic [3:0] s,
                         input logic tl, input logic [3:0] ti, input logic cp);
        rst_n = rn; sample_valid = v; sample = s; thr_load = tl; thr_in = ti; clear_peak = cp;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got a/b/e/al/pk/pv=%b required=%b", name, act, req);
        end
    endtask

    // Reference model: run lengths as integers, peak as the max over samples kept since clear.
    int m_thr, m_flag;
    int m_run[2];
    bit m_alarm[2];
    int m_q[$];
    int debv[2] = '{3, 1};

    task automatic model_step(input bit rn, input bit v, input int s,
                              input bit tl, input int ti, input bit cp);
        bit qual;
        if (!rn) begin
            m_thr = 8; m_flag = -1;
            for (int k = 0; k < 2; k++) begin m_run[k] = 0; m_alarm[k] = 0; end
            m_q.delete();
        end else if (tl) begin
            m_thr = ti;
            for (int k = 0; k < 2; k++) m_run[k] = 0;
            if (cp) m_q.delete();
        end else if (v) begin
            m_flag = (s > m_thr) ? 2 : (s < m_thr) ? 0 : 1;
            for (int k = 0; k < 2; k++) begin
                qual = m_alarm[k] ? (s < m_thr) : (s > m_thr);
                m_run[k] = qual ? m_run[k] + 1 : 0;
                if (m_run[k] == debv[k]) begin
                    m_alarm[k] = !m_alarm[k];
                    m_run[k]   = 0;
                end
            end
            if (cp) m_q.delete();
            m_q.push_back(s);
        end else if (cp) begin
            m_q.delete();
        end
    endtask

    function automatic logic [8:0] model_out(input int k);
        int mx = 0;
        foreach (m_q[i]) if (m_q[i] > mx) mx = m_q[i];
        return {1'(m_flag == 2), 1'(m_flag == 0), 1'(m_flag == 1), 1'(m_alarm[k]),
                4'(mx), 1'(m_q.size() > 0)};
    endfunction

    initial begin
        drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

        //             rn v  s  tl ti cp   a b e al pk pv
        tbl.push_back(mk(0, 1, 9, 0, 0, 0,  0,0,0,0, 0,0));
        tbl.push_back(mk(0, 1, 3, 1, 2, 1,  0,0,0,0, 0,0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0, 9,1));
        tbl.push_back(mk(0, 1, 9, 0, 0, 0,  0,0,0,0, 0,0));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0, 9,1));
        tbl.push_back(mk(1, 1,10, 0, 0, 0,  1,0,0,0,10,1));
        tbl.push_back(mk(1, 1, 8, 0, 0, 0,  0,0,1,0,10,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0,10,1));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0,  0,1,0,0,10,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0,10,1));
        tbl.push_back(mk(1, 1,10, 0, 0, 0,  1,0,0,0,10,1));
        tbl.push_back(mk(1, 1,15, 0, 0, 0,  1,0,0,1,15,1));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0,  0,1,0,1,15,1));
        tbl.push_back(mk(1, 1, 8, 0, 0, 0,  0,0,1,1,15,1));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0,  0,1,0,1,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,1,0,1,15,1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,1,0,0,15,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 0,15, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 0, 8, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,1,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,1,0,1,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,1,0,1,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,1,0,0,15,1));
        tbl.push_back(mk(1, 1, 9, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1,10, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 7, 1, 2, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0,  1,0,0,1,15,1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1,0,0,1, 0,0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 0,  1,0,0,1, 4,1));
        tbl.push_back(mk(1, 1,12, 0, 0, 0,  1,0,0,1,12,1));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0,  1,0,0,1,12,1));
        tbl.push_back(mk(1, 1, 5, 0, 0, 1,  1,0,0,1, 5,1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  1,0,0,1, 0,0));
        tbl.push_back(mk(1, 0, 0, 1,15, 0,  1,0,0,1, 0,0));
        tbl.push_back(mk(1, 1,14, 0, 0, 0,  0,1,0,1,14,1));
        tbl.push_back(mk(1, 1,14, 0, 0, 0,  0,1,0,1,14,1));
        tbl.push_back(mk(1, 1,14, 0, 0, 0,  0,1,0,0,14,1));
        tbl.push_back(mk(1, 1,15, 0, 0, 0,  0,0,1,0,15,1));
        tbl.push_back(mk(1, 1,15, 0, 0, 0,  0,0,1,0,15,1));
        tbl.push_back(mk(1, 1,15, 0, 0, 0,  0,0,1,0,15,1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0,  0,0,1,0,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,0,0,0,15,1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,0,0,1,15,1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,0,1,1,15,1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,0,1,1,15,1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,0,1,1,15,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].v, tbl[i].s, tbl[i].tl, tbl[i].ti, tbl[i].cp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {above, below, equal, alarm, peak, peak_valid}, tbl[i].exp);
        end

        // Random phase: both instances against the model, starting from reset.
        for (int i = 0; i < 3000; i++) begin
            bit       rn, v, tl, cp;
            int       s, ti;
            rn = (i < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            v  = ($urandom_range(0, 99) < 70);
            tl = ($urandom_range(0, 99) < 6);
            cp = ($urandom_range(0, 99) < 6);
            s  = $urandom_range(0, 15);
            ti = $urandom_range(0, 15);
            if (tl && v) cp = 1'b0;
            drive(rn, v, 4'(s), tl, 4'(ti), cp);
            model_step(rn, v, s, tl, ti, cp);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_deb3", i), {above, below, equal, alarm, peak, peak_valid}, model_out(0));
            check($sformatf("rnd%0d_deb1", i), {above1, below1, equal1, alarm1, peak1, peak_valid1}, model_out(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/threshold_monitor_4bit.md
Name: threshold_monitor_4bit

Overview:
Registered, debounced magnitude monitor that sits directly downstream of the 4-bit comparator stage. It compares each valid 4-bit sample against a programmable threshold using greater/less/equal semantics, and registers the per-sample compare flags. It drives a hysteresis-debounced alarm and tracks the peak sample seen. It feeds the alarm/status logic of the datapath.

Parameters:
DATA_W, 4, sample and threshold width
DEBOUNCE, 3, consecutive qualifying samples needed to change alarm state (1..15); counter width is ceil(log2(DEBOUNCE+1)), derived internally
THR_RESET, 4'b1000, threshold value after reset

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
sample_valid  in  1  sample qualifier; sample is consumed on any edge where high (no backpressure)
sample  in  DATA_W  unsigned sample value
thr_load  in  1  load thr_in into threshold register
thr_in  in  DATA_W  new unsigned threshold
clear_peak  in  1  restart peak tracking
above  out  1  registered: last valid sample > threshold
below  out  1  registered: last valid sample < threshold
equal  out  1  registered: last valid sample == threshold
alarm  out  1  debounced alarm state
peak  out  DATA_W  max valid sample since reset/clear
peak_valid  out  1  peak holds at least one sample

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n). Reset is sampled only on a rising clk edge.
- Reset values:
  - threshold=THR_RESET; above/below/equal=0; alarm=0; peak=0; peak_valid=0.
  - Debounce counter=0; FSM=LOW.
  - Reset dominates all other inputs, including in the middle of a debounce sequence.
- Compare: unsigned, full DATA_W width. Exactly one of above/below/equal is 1 after the first valid sample. Flags update on the edge that consumes a valid sample and hold while sample_valid=0.
- Latency: flags, alarm transition and peak all update on the same edge that consumes the sample (1-cycle registered).
- FSM states:
  - LOW (alarm=0):
    - valid sample > thr: cnt+1.
    - valid sample <= thr: cnt=0.
    - When the increment would reach DEBOUNCE: go to HIGH, alarm=1, cnt=0.
  - HIGH (alarm=1):
    - valid sample < thr: cnt+1.
    - valid sample >= thr: cnt=0.
    - When the increment would reach DEBOUNCE: go to LOW, alarm=0, cnt=0.
  - Equal samples never advance the counter in either state; this is the hysteresis band.
  - sample_valid=0 cycles neither advance nor clear cnt, so consecutiveness is counted in valid samples only.
- Threshold load:
  - On thr_load=1: threshold<=thr_in; cnt<=0; FSM/alarm unchanged.
  - If sample_valid=1 in the same cycle, the sample is dropped entirely: flags, cnt and peak are unchanged.
- Peak tracking:
  - On a valid sample: if peak_valid=0 or sample>peak, then peak<=sample and peak_valid<=1.
  - clear_peak=1 with no valid sample: peak<=0, peak_valid<=0.
  - clear_peak=1 with a valid, not-dropped sample: peak<=sample, peak_valid<=1.
  - A sample dropped by thr_load does not enter peak, even when clear_peak is high.
- Boundaries:
  - thr=4'hF: above is never set and alarm can never rise.
  - thr=4'h0: below is never set and the alarm, once high, can never clear.
  - DEBOUNCE=1: alarm changes on the first qualifying sample.
  - cnt cannot overflow, because it clears on reaching DEBOUNCE.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with random inputs -> all outputs 0, threshold=8. Apply sample 9 valid, then rst_n=0 -> next edge flags=0, cnt reset.
- Debounce rise: thr=8, samples 9,10,15 consecutive -> above=1 each edge; alarm rises on the 3rd sample's edge. A prior sequence 9,10,8,9 -> alarm stays 0 (equal clears cnt).
- Hysteresis fall: in HIGH, samples 3,8,2,1,0 -> equal=1 on 8; alarm falls only on the edge consuming 0 (the third consecutive below sample after 8).
- Gaps: thr=8, samples 9,(valid=0 for 4 cycles),9,9 -> alarm rises on the last 9. Flags hold through the gap.
- Threshold load collision: thr_load=1, thr_in=2 with sample_valid=1, sample=7 after two above samples -> threshold=2, cnt=0, flags/peak unchanged. Next sample 3 -> above=1, cnt=1.
- Peak: samples 4,12,7 -> peak=12, peak_valid=1. clear_peak with valid sample 5 -> peak=5. clear_peak alone -> peak=0, peak_valid=0.
